button_repeat_debouncer: RTL and testbench

Multi-channel successor to the single-button debouncer. It synchronises N_CH raw push-button inputs and qualifies each press after a programmable hold time. While a button stays held, it emits typematic auto-repeat pulses. It sits between the board buttons and the game controller, which consumes one-cycle `press_pulse` strobes and an encoded `press_idx` of the lowest-numbered active strobe.

---
 rtl/button_repeat_debouncer_pkg.sv | 10 +
 rtl/button_repeat_channel.sv | 86 ++++++++
 rtl/button_repeat_debouncer.sv | 37 +++
 tb/tb_button_repeat_debouncer.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/button_repeat_debouncer_pkg.sv
// button_repeat_debouncer_pkg: shared FSM encoding and default sizing for the multi-channel button debouncer.
package button_repeat_debouncer_pkg;
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ARM  = 2'd1,
    HOLD = 2'd2
  } deb_state_e;
  localparam int DEB_N_CH = 5;
  localparam int DEB_CNT_W = 7;
endpackage

// File: rtl/button_repeat_channel.sv
// button_repeat_channel: one button's synchroniser, IDLE/ARM/HOLD FSM, hold counter and pulse register.
// Auto-repeat in HOLD exists only when DEBOUNCE_REPEAT_EN is defined.
module button_repeat_channel
  import button_repeat_debouncer_pkg::*;
#(
  parameter int CNT_W = DEB_CNT_W
) (
  input  logic             logicclk,
  input  logic             clr,
  input  logic             btn,
  input  logic [CNT_W-1:0] t,
  input  logic [CNT_W-1:0] r,
  output logic             pulse,
  output logic             held
);
  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);
  logic [1:0] sync;
  logic btn_s;
  deb_state_e state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n, t_eff;
  logic pulse_n;
  assign btn_s = sync[1];
  assign t_eff = (t == '0) ? ONE : t;
  assign held = state == HOLD;
`ifdef DEBOUNCE_REPEAT_EN
  logic [CNT_W-1:0] r_last;
  assign r_last = (r == '0) ? '0 : r - ONE;
`else
  logic unused_r;
  assign unused_r = ^r;
`endif
  // thresholds use >= so a live drop of t or r fires on the next edge instead of wrapping
  always_comb begin
    state_n = state;
    cnt_n = cnt;
    pulse_n = 1'b0;
    case (state)
      IDLE: begin
        state_n = btn_s ? ARM : IDLE;
        cnt_n = btn_s ? ONE : '0;
      end
      ARM: begin
        if (!btn_s) begin
          state_n = IDLE;
          cnt_n = '0;
        end else if (cnt >= t_eff) begin
          pulse_n = 1'b1;
          state_n = HOLD;
          cnt_n = '0;
        end else begin
          cnt_n = cnt + ONE;
        end
      end
      HOLD: begin
        if (!btn_s) begin
          state_n = IDLE;
          cnt_n = '0;
`ifdef DEBOUNCE_REPEAT_EN
        end else if (cnt >= r_last) begin
          pulse_n = 1'b1;
          cnt_n = '0;
        end else begin
          cnt_n = cnt + ONE;
`endif
        end
      end
      default: begin
        state_n = IDLE;
        cnt_n = '0;
      end
    endcase
  end
  always_ff @(posedge logicclk or posedge clr) begin
    if (clr) begin
      sync <= '0;
      state <= IDLE;
      cnt <= '0;
      pulse <= 1'b0;
    end else begin
      sync <= {sync[0], btn};
      state <= state_n;
      cnt <= cnt_n;
      pulse <= pulse_n;
    end
  end
endmodule

// File: rtl/button_repeat_debouncer.sv
// button_repeat_debouncer: N_CH independent debounced buttons with hold qualification and optional
// typematic repeat (DEBOUNCE_REPEAT_EN), plus OR-reduction and lowest-index priority encoder.
module button_repeat_debouncer
  import button_repeat_debouncer_pkg::*;
#(
  parameter int N_CH = DEB_N_CH,
  parameter int CNT_W = DEB_CNT_W,
  parameter int IDX_W = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic             logicclk,
  input  logic             clr,
  input  logic [N_CH-1:0]  button,
  input  logic [CNT_W-1:0] time_to_first_press,
  input  logic [CNT_W-1:0] repeat_interval,
  output logic [N_CH-1:0]  press_pulse,
  output logic [N_CH-1:0]  held,
  output logic             any_pulse,
  output logic [IDX_W-1:0] press_idx
);
  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    button_repeat_channel #(.CNT_W(CNT_W)) u_ch (
      .logicclk(logicclk),
      .clr(clr),
      .btn(button[i]),
      .t(time_to_first_press),
      .r(repeat_interval),
      .pulse(press_pulse[i]),
      .held(held[i])
    );
  end
  assign any_pulse = |press_pulse;
  // scan downward so the lowest set bit is the last to write
  always_comb begin
    press_idx = '0;
    for (int i = N_CH - 1; i >= 0; i--) press_idx = press_pulse[i] ? IDX_W'(i) : press_idx;
  end
endmodule

// File: tb/tb_button_repeat_debouncer.sv
// tb_button_repeat_debouncer: directed stimulus with a pulse scoreboard; expectations follow DEBOUNCE_REPEAT_EN.
module tb_button_repeat_debouncer;
  logic logicclk = 1'b0;
  logic clr = 1'b1;
  logic [4:0] button = '0;
  logic [6:0] t = 7'd4;
  logic [6:0] r = 7'd3;
  logic [4:0] press_pulse, held;
  logic any_pulse;
  logic [2:0] press_idx;
  int cyc = 0;
  int n_chk = 0;
  int n_fail = 0;
  typedef struct {
    int c;
    logic [4:0] v;
    logic [2:0] i;
  } exp_t;
  exp_t q[$];

  button_repeat_debouncer dut (
    .logicclk(logicclk),
    .clr(clr),
    .button(button),
    .time_to_first_press(t),
    .repeat_interval(r),
    .press_pulse(press_pulse),
    .held(held),
    .any_pulse(any_pulse),
    .press_idx(press_idx)
  );

  always #5 logicclk = ~logicclk;
  always @(posedge logicclk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s at edge %0d: got %0h, expected %0h", name, cyc, act, req);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge logicclk);
  endtask

  task automatic push(input int c, input logic [4:0] v, input logic [2:0] i);
    exp_t e;
    e.c = c;
    e.v = v;
    e.i = i;
    q.push_back(e);
  endtask

  always @(negedge logicclk) begin
    exp_t e;
    while (q.size() > 0 && q[0].c < cyc) begin
      n_chk++;
      n_fail++;
      $display("FAIL missed_pulse: expected vec %b after edge %0d, got none", q[0].v, q[0].c);
      void'(q.pop_front());
    end
    if (press_pulse != '0 || any_pulse) begin
      if (q.size() == 0 || q[0].c != cyc) begin
        n_chk++;
        n_fail++;
        $display("FAIL unexpected_pulse after edge %0d: got vec %b, expected none", cyc, press_pulse);
      end else begin
        e = q.pop_front();
        chk("pulse_vec", press_pulse, e.v);
        chk("press_idx", press_idx, e.i);
        chk("any_pulse", any_pulse, 1);
      end
    end else begin
      chk("idle_idx", press_idx, 0);
    end
  end

  initial begin
    int s;
    tick(3);
    chk("rst_pulse", press_pulse, 0);
    chk("rst_held", held, 0);
    chk("rst_any", any_pulse, 0);
    chk("rst_idx", press_idx, 0);
    clr = 1'b0;
    tick(3);
    chk("idle_held", held, 0);
    // reset mid-ARM, then a long hold with T=4, R=3
    button[0] = 1'b1;
    tick(4);
    clr = 1'b1;
    tick(2);
    chk("clr_held", held, 0);
    s = cyc;
    clr = 1'b0;
`ifdef DEBOUNCE_REPEAT_EN
    for (int k = 0; k <= 8; k++) push(s + 7 + 3 * k, 5'b00001, 3'd0);
`else
    push(s + 7, 5'b00001, 3'd0);
`endif
    tick(6);
    chk("held_before_t", held[0], 0);
    tick(1);
    chk("held_at_t", held[0], 1);
    tick(23);
    button[0] = 1'b0;
    tick(2);
    chk("held_release_2", held[0], 1);
    tick(1);
    chk("held_release_3", held[0], 0);
    tick(5);
    // short glitch and release exactly on the threshold cycle
    t = 7'd10;
    button[1] = 1'b1;
    tick(8);
    button[1] = 1'b0;
    tick(8);
    chk("glitch_held", held[1], 0);
    button[1] = 1'b1;
    tick(10);
    button[1] = 1'b0;
    tick(3);
    chk("thresh_release_held", held[1], 0);
    tick(5);
    // T=0 and R=0 act as 1
    t = 7'd0;
    r = 7'd0;
    s = cyc;
    button[2] = 1'b1;
`ifdef DEBOUNCE_REPEAT_EN
    for (int k = 4; k <= 12; k++) push(s + k, 5'b00100, 3'd2);
`else
    push(s + 4, 5'b00100, 3'd2);
`endif
    tick(10);
    button[2] = 1'b0;
    tick(3);
    chk("zero_t_held", held[2], 0);
    tick(4);
    // simultaneous presses on channels 3 and 1
    t = 7'd2;
    r = 7'd100;
    s = cyc;
    button = 5'b01010;
    push(s + 5, 5'b01010, 3'd1);
    tick(6);
    chk("multi_held", held, 5'b01010);
    button = '0;
    tick(6);
    chk("multi_release", held, 0);
    // 50-cycle hold with T=3, R=10
    t = 7'd3;
    r = 7'd10;
    s = cyc;
    button[4] = 1'b1;
`ifdef DEBOUNCE_REPEAT_EN
    for (int k = 0; k <= 4; k++) push(s + 6 + 10 * k, 5'b10000, 3'd4);
`else
    push(s + 6, 5'b10000, 3'd4);
`endif
    tick(50);
    button[4] = 1'b0;
    tick(2);
    chk("long_held", held[4], 1);
    tick(1);
    chk("long_release", held[4], 0);
    tick(4);
    // lowering T mid-count fires on the next edge
    t = 7'd20;
    r = 7'd100;
    s = cyc;
    button[0] = 1'b1;
    tick(7);
    chk("live_t_wait", held[0], 0);
    t = 7'd2;
    push(s + 8, 5'b00001, 3'd0);
    tick(1);
    chk("live_t_held", held[0], 1);
    tick(3);
    button[0] = 1'b0;
    tick(6);
    chk("live_t_release", held[0], 0);
    tick(5);
    chk("queue_empty", q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
